// File: rtl/ysyx_24120013_ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one outstanding instruction read at
// a time and hands the returned word with its PC to the IDU over valid/ready.
module ysyx_24120013_ifu_fetch #(
  parameter int unsigned               ADDR_WIDTH = 32,
  parameter int unsigned               DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]     RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  input  logic [DATA_WIDTH-1:0] ifu_rsp_data,
  input  logic                  ifu_rsp_err,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] IFU_inst,
  output logic [ADDR_WIDTH-1:0] IFU_pc,
  output logic                  IFU_valid,
  input  logic                  IDU_ready,
  output logic                  IFU_fault
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  discard_q,  discard_d;
  logic [DATA_WIDTH-1:0] inst_q,     inst_d;
  logic [ADDR_WIDTH-1:0] ipc_q,      ipc_d;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  redir_bad;

  assign pc_plus4  = pc_q + ADDR_WIDTH'(4);
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // req_addr is kept apart from pc so a redirect cannot disturb a request that
  // is still waiting for ifu_req_ready.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    inst_d     = inst_q;
    ipc_d      = ipc_q;
    case (state_q)
      S_REQ: begin
        if (ifu_req_ready) state_d = S_WAIT;
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          discard_d = 1'b1;
        end
        if (redir_bad) state_d = S_HALT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          discard_d = 1'b1;
        end
        if (ifu_rsp_valid) begin
          if (discard_q || redirect_valid) begin
            discard_d  = 1'b0;
            state_d    = S_REQ;
            req_addr_d = redirect_valid ? redirect_pc : pc_q;
          end else if (ifu_rsp_err) begin
            state_d = S_HALT;
          end else begin
            inst_d  = ifu_rsp_data;
            ipc_d   = pc_q;
            state_d = S_HOLD;
          end
        end
        if (redir_bad) state_d = S_HALT;
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = S_REQ;
        end else if (IDU_ready) begin
          pc_d       = pc_plus4;
          req_addr_d = pc_plus4;
          state_d    = S_REQ;
        end
        if (redir_bad) state_d = S_HALT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      discard_q  <= 1'b0;
      inst_q     <= '0;
      ipc_q      <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
      inst_q     <= inst_d;
      ipc_q      <= ipc_d;
    end
  end

  assign ifu_req_valid = rst && (state_q == S_REQ);
  assign ifu_req_addr  = req_addr_q;
  assign IFU_valid     = (state_q == S_HOLD);
  assign IFU_fault     = (state_q == S_HALT);
  assign IFU_inst      = inst_q;
  assign IFU_pc        = ipc_q;

endmodule

// File: tb/tb_ysyx_24120013_ifu_fetch.sv
// Bench for ysyx_24120013_ifu_fetch: memory model, scoreboard of expected
// (pc, inst) deliveries, directed scenarios and a randomized run.
module tb_ysyx_24120013_ifu_fetch;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] IFU_inst, IFU_pc;
  logic        IFU_valid, IDU_ready, IFU_fault;

  ysyx_24120013_ifu_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .IFU_inst(IFU_inst), .IFU_pc(IFU_pc), .IFU_valid(IFU_valid),
    .IDU_ready(IDU_ready), .IFU_fault(IFU_fault)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0, miscompares = 0, delivered = 0;

  // stimulus knobs
  int unsigned rdy_pct, idu_pct, redir_pct, lat_min, lat_max;
  bit          f_redir, trig_en, trig_hit, err_en, err_issued, stale_rsp;
  logic [31:0] f_pc, trig_pc, trig_tgt, err_addr;
  // memory model
  bit          pend, hs_sched;
  int unsigned wcnt;
  logic [31:0] pend_addr, hs_addr;
  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_next, mon_e;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decide this cycle's inputs from the DUT's registered outputs; record the
  // expected next delivery whenever a redirect or consumption is issued.
  task automatic drive();
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    ifu_rsp_data  = $urandom;
    err_issued    = 1'b0;
    if (hs_sched) begin
      pend = 1'b1; pend_addr = hs_addr; wcnt = $urandom_range(lat_max, lat_min); hs_sched = 1'b0;
    end
    if (pend) begin
      wcnt--;
      if (wcnt == 0) begin
        pend = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_data = memf(pend_addr);
        if (err_en && pend_addr == err_addr) begin ifu_rsp_err = 1'b1; err_issued = 1'b1; end
      end
    end else if (stale_rsp) begin
      ifu_rsp_valid = 1'b1; ifu_rsp_data = 32'hDEAD_BEEF;
    end
    stale_rsp = 1'b0;
    if (!ifu_rsp_valid) ifu_rsp_err = ($urandom_range(3, 0) == 0);
    ifu_req_ready = ($urandom_range(99, 0) < rdy_pct);
    hs_sched = ifu_req_valid && ifu_req_ready;
    hs_addr  = ifu_req_addr;
    IDU_ready = ($urandom_range(99, 0) < idu_pct);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (f_redir) begin
      redirect_valid = 1'b1; redirect_pc = f_pc; f_redir = 1'b0;
    end else if (trig_en && IFU_valid && IFU_pc == trig_pc) begin
      redirect_valid = 1'b1; redirect_pc = trig_tgt; IDU_ready = 1'b1; trig_en = 1'b0; trig_hit = 1'b1;
    end else if ($urandom_range(99, 0) < redir_pct) begin
      redirect_valid = 1'b1; redirect_pc = RPC + ($urandom_range(255, 0) << 2);
    end
    if (!IFU_fault) begin
      if (redirect_valid) begin
        if (redirect_pc[1:0] == 2'b00) begin
          exp_q.delete(); exp_next = redirect_pc; exp_q.push_back(exp_next);
        end
      end else if (IFU_valid && IDU_ready) begin
        exp_next = exp_next + 32'd4; exp_q.push_back(exp_next);
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
    drive();
  endtask

  task automatic reset_dut(input bit stale);
    @(posedge clk); #2;
    rst = 1'b0;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0; ifu_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; IDU_ready = 1'b0;
    pend = 1'b0; hs_sched = 1'b0; trig_en = 1'b0; trig_hit = 1'b0;
    #1;
    chk("rst_req_valid", ifu_req_valid, 0);
    chk("rst_ifu_valid", IFU_valid, 0);
    chk("rst_ifu_inst", IFU_inst, 0);
    chk("rst_ifu_pc", IFU_pc, RPC);
    chk("rst_ifu_fault", IFU_fault, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete(); exp_next = RPC; exp_q.push_back(RPC);
    stale_rsp = stale;
    #1;
    drive();
    chk("first_req_valid", ifu_req_valid, 1);
    chk("first_req_addr", ifu_req_addr, RPC);
  endtask

  task automatic wait_valid(input string name);
    int unsigned n = 0;
    do begin step(); n++; end while (!IFU_valid && n < 40);
    vectors++;
    if (!IFU_valid) begin
      miscompares++;
      $display("FAIL %s: IFU_valid got 0 after 40 cycles, expected 1", name);
    end
  endtask

  // Monitor: pops the scoreboard on every IDU handshake and checks hold rules.
  logic        p_req, p_rdy, p_iv, p_idu, p_redir, p_bad;
  logic [31:0] p_addr, p_ipc, p_inst;
  always @(negedge clk) begin
    if (!rst) begin
      p_req = 1'b0; p_iv = 1'b0;
    end else begin
      if (IFU_fault) begin
        chk("halt_req_valid", ifu_req_valid, 0);
        chk("halt_ifu_valid", IFU_valid, 0);
      end
      if (p_req && !p_rdy && !p_bad) begin
        chk("req_valid_hold", ifu_req_valid, 1);
        chk("req_addr_hold", ifu_req_addr, p_addr);
      end
      if (p_iv && !p_idu && !p_redir) begin
        chk("ifu_valid_hold", IFU_valid, 1);
        chk("ifu_pc_hold", IFU_pc, p_ipc);
        chk("ifu_inst_hold", IFU_inst, p_inst);
      end
      if (IFU_valid && IDU_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL deliver: got pc %h, expected no delivery pending", IFU_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("deliver_pc", IFU_pc, mon_e);
          chk("deliver_inst", IFU_inst, memf(mon_e));
          delivered++;
        end
      end
      p_req = ifu_req_valid; p_rdy = ifu_req_ready; p_addr = ifu_req_addr;
      p_iv = IFU_valid; p_idu = IDU_ready; p_ipc = IFU_pc; p_inst = IFU_inst;
      p_redir = redirect_valid;
      p_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation got no end, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc0, inst0;
    int unsigned d0;
    bit found;
    rst = 1'b0;
    f_redir = 0; trig_en = 0; trig_hit = 0; err_en = 0; err_issued = 0; stale_rsp = 0;
    f_pc = '0; trig_pc = '0; trig_tgt = '0; err_addr = '0; pend = 0; hs_sched = 0;
    rdy_pct = 100; idu_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;

    // back-to-back fetch: 3 cycles per instruction
    reset_dut(0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      chk("t1_req_valid", ifu_req_valid, (k % 3 == 0));
      chk("t1_ifu_valid", IFU_valid, (k % 3 == 2));
      if (k % 3 == 0) chk("t1_req_addr", ifu_req_addr, RPC + 32'(4 * (k / 3)));
      if (k % 3 == 2) chk("t1_ifu_pc", IFU_pc, RPC + 32'(4 * (k / 3)));
    end

    // IDU stall for 5 cycles
    idu_pct = 0;
    wait_valid("t2_wait");
    pc0 = IFU_pc; inst0 = IFU_inst;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      chk("t2_valid", IFU_valid, 1);
      chk("t2_no_req", ifu_req_valid, 0);
      chk("t2_pc", IFU_pc, pc0);
      chk("t2_inst", IFU_inst, inst0);
    end
    idu_pct = 100;
    step();
    chk("t2_valid_last", IFU_valid, 1);
    step();
    chk("t2_next_req", ifu_req_valid, 1);
    chk("t2_next_addr", ifu_req_addr, pc0 + 32'd4);

    // redirect while the request is held by ifu_req_ready=0
    rdy_pct = 0;
    reset_dut(0);
    for (int k = 1; k < 5; k++) begin
      if (k == 2) begin f_redir = 1; f_pc = RPC + 32'h100; end
      if (k == 4) rdy_pct = 100;
      step();
      chk("t3_req_valid", ifu_req_valid, 1);
      chk("t3_req_addr", ifu_req_addr, RPC);
    end
    wait_valid("t3_wait");
    chk("t3_ifu_pc", IFU_pc, RPC + 32'h100);

    // redirect wins over a simultaneous IDU handshake
    reset_dut(0);
    trig_en = 1; trig_pc = RPC + 32'h8; trig_tgt = RPC + 32'h40;
    for (int i = 0; i < 30 && !trig_hit; i++) step();
    chk("t4_trigger", trig_hit, 1);
    step();
    chk("t4_req_valid", ifu_req_valid, 1);
    chk("t4_req_addr", ifu_req_addr, RPC + 32'h40);
    wait_valid("t4_wait");
    chk("t4_ifu_pc", IFU_pc, RPC + 32'h40);

    // access fault halts fetching until reset
    reset_dut(0);
    err_en = 1; err_addr = RPC + 32'h4; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (err_issued) begin
        step();
        found = 1;
        chk("t5_fault", IFU_fault, 1);
        chk("t5_valid", IFU_valid, 0);
      end
    end
    chk("t5_err_seen", found, 1);
    f_redir = 1; f_pc = RPC;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_halt_req", ifu_req_valid, 0);
      chk("t5_halt_fault", IFU_fault, 1);
    end
    err_en = 0;
    reset_dut(0);
    chk("t5_fault_clr", IFU_fault, 0);

    // PC wraps past the top of the address space
    f_redir = 1; f_pc = 32'hFFFF_FFFC;
    reset_dut(0);
    wait_valid("t6_wait");
    chk("t6_ifu_pc", IFU_pc, 32'hFFFF_FFFC);
    step();
    chk("t6_req_valid", ifu_req_valid, 1);
    chk("t6_req_addr", ifu_req_addr, 32'h0000_0000);

    // misaligned redirect target
    reset_dut(0);
    step(); step();
    f_redir = 1; f_pc = RPC + 32'h102;
    step(); step();
    chk("t7_fault", IFU_fault, 1);

    // randomized traffic with a mid-run reset and stale responses after release
    rdy_pct = 70; idu_pct = 60; redir_pct = 5; lat_min = 1; lat_max = 3;
    reset_dut(1);
    d0 = delivered;
    for (int i = 0; i < 1500; i++) step();
    reset_dut(1);
    for (int i = 0; i < 1500; i++) step();
    chk("t8_progress", (delivered - d0) >= 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
